// File: rtl/tdc_csrfifo_pkg.sv
// Shared definitions for the TDC timestamp FIFO CSR block: register map,
// field positions, entry layout and the saturating drop-counter helper.
package tdc_csrfifo_pkg;

  // Register indices (csr_a[2:0])
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_HEAD_TS  = 3'd1;
  localparam logic [2:0] REG_HEAD_POL = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_THRESH   = 3'd4;
  localparam logic [2:0] REG_DROPS    = 3'd5;

  // STATUS bit positions
  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_LVL_LSB = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_POP    = 2;
  localparam int unsigned CTRL_FLUSH  = 3;

  // Entry: {polarity, timestamp}
  localparam int unsigned TS_W     = 32;
  localparam int unsigned ENTRY_W  = 33;
  localparam int unsigned DROPS_W  = 16;
  localparam int unsigned THRESH_W = 5;

  typedef struct packed {
    logic            pol;
    logic [TS_W-1:0] ts;
  } entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROPS_W-1:0] drops_sat_inc(input logic [DROPS_W-1:0] v);
    logic [DROPS_W-1:0] r;
    r = (v == {DROPS_W{1'b1}}) ? v : (v + {{(DROPS_W-1){1'b0}}, 1'b1});
    return r;
  endfunction

endpackage

// File: rtl/tdc_fifo_sync.sv
// Synchronous FIFO with distributed-RAM storage, asynchronous read of the
// head entry, and push/pop/flush control. Flush wins over push and pop.
module tdc_fifo_sync #(
  parameter int unsigned width      = 33,
  parameter int unsigned depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  localparam int unsigned         DEPTH      = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_LEVEL = {1'b1, {depth_log2{1'b0}}};
  localparam logic [depth_log2:0] LEVEL_ONE  = {{depth_log2{1'b0}}, 1'b1};
  localparam logic [depth_log2-1:0] PTR_ONE  = {{(depth_log2-1){1'b0}}, 1'b1};

  logic [width-1:0]      mem_r [0:DEPTH-1];
  logic [depth_log2-1:0] wr_ptr_r;
  logic [depth_log2-1:0] rd_ptr_r;
  logic [depth_log2:0]   level_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (level_r == FULL_LEVEL);
  assign empty     = (level_r == {(depth_log2+1){1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full & ~flush;
  assign pop_ok_s  = pop & ~empty & ~flush;

  // Storage write; the array carries no reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {depth_log2{1'b0}};
      rd_ptr_r <= {depth_log2{1'b0}};
      level_r  <= {(depth_log2+1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      level_r  <= {(depth_log2+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/tdc_csrfifo.sv
// CSR front end for the TDC timestamp FIFO: register decode, enable and
// interrupt control, overflow/drop accounting and a level interrupt.
module tdc_csrfifo
  import tdc_csrfifo_pkg::*;
#(
  parameter logic [3:0]  csr_addr   = 4'h2,
  parameter int unsigned depth_log2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        ts_valid_i,
  input  logic [31:0] ts_i,
  input  logic        ts_pol_i,
  output logic        ts_ready_o,
  output logic        irq
);

  localparam int unsigned LVL_W = depth_log2 + 1;
  localparam int unsigned CMP_W = (LVL_W > THRESH_W) ? LVL_W : THRESH_W;

  logic                sel_s;
  logic                csr_wr_s;
  logic [2:0]          idx_s;
  logic                push_s;
  logic                pop_s;
  logic                flush_s;
  logic                drop_s;
  logic                full_s;
  logic                empty_s;
  logic [LVL_W-1:0]    level_s;
  logic [ENTRY_W-1:0]  head_raw_s;
  logic [ENTRY_W-1:0]  wentry_s;
  entry_t              head_s;
  logic [CMP_W-1:0]    level_ext_s;
  logic [CMP_W-1:0]    thresh_ext_s;
  logic                irq_next_s;
  logic [31:0]         rdata_s;
  logic                unused_s;

  logic                enable_r;
  logic                irq_en_r;
  logic                overflow_r;
  logic [THRESH_W-1:0] thresh_r;
  logic [DROPS_W-1:0]  drops_r;
  logic [31:0]         csr_do_r;
  logic                irq_r;

  assign ts_ready_o = enable_r & ~full_s;
  assign push_s     = ts_valid_i & ts_ready_o;
  assign wentry_s   = {ts_pol_i, ts_i};
  assign head_s     = entry_t'(head_raw_s);
  assign csr_do     = csr_do_r;
  assign irq        = irq_r;
  assign unused_s   = ^{csr_a[9:3], csr_di[31:THRESH_W]};

  // Page select, register index and write-pulse decode.
  always_comb begin
    sel_s    = (csr_a[13:10] == csr_addr);
    idx_s    = csr_a[2:0];
    csr_wr_s = csr_we & sel_s;
    pop_s    = csr_wr_s & (idx_s == REG_CTRL) & csr_di[CTRL_POP];
    flush_s  = csr_wr_s & (idx_s == REG_CTRL) & csr_di[CTRL_FLUSH];
    drop_s   = ts_valid_i & enable_r & full_s;
  end

  tdc_fifo_sync #(
    .width      (ENTRY_W),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata (wentry_s),
    .rdata (head_raw_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Software-writable control fields: enable, irq_en and threshold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enable_r <= 1'b0;
      irq_en_r <= 1'b0;
      thresh_r <= {THRESH_W{1'b0}};
    end else begin
      if (csr_wr_s && (idx_s == REG_CTRL)) begin
        enable_r <= csr_di[CTRL_EN];
        irq_en_r <= csr_di[CTRL_IRQ_EN];
      end
      if (csr_wr_s && (idx_s == REG_THRESH)) begin
        thresh_r <= csr_di[THRESH_W-1:0];
      end
    end
  end

  // Sticky overflow flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (csr_wr_s && (idx_s == REG_STATUS) && csr_di[STAT_OVF]) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Saturating drop counter; any write to DROPS clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drops_r <= {DROPS_W{1'b0}};
    end else if (csr_wr_s && (idx_s == REG_DROPS)) begin
      drops_r <= {DROPS_W{1'b0}};
    end else if (drop_s) begin
      drops_r <= drops_sat_inc(drops_r);
    end else begin
      drops_r <= drops_r;
    end
  end

  // Interrupt condition from current state: overflow or level at/above threshold.
  always_comb begin
    level_ext_s  = CMP_W'(level_s);
    thresh_ext_s = CMP_W'(thresh_r);
    irq_next_s   = irq_en_r &
                   (overflow_r | ((thresh_r != {THRESH_W{1'b0}}) & (level_ext_s >= thresh_ext_s)));
  end

  // Registered interrupt output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_next_s;
    end
  end

  // Read multiplexer; unmapped indices return zero.
  always_comb begin
    rdata_s = 32'd0;
    case (idx_s)
      REG_STATUS: begin
        rdata_s[STAT_EMPTY]              = empty_s;
        rdata_s[STAT_FULL]               = full_s;
        rdata_s[STAT_OVF]                = overflow_r;
        rdata_s[STAT_LVL_LSB +: LVL_W]   = level_s;
      end
      REG_HEAD_TS:  rdata_s = empty_s ? 32'd0 : head_s.ts;
      REG_HEAD_POL: rdata_s[0] = ~empty_s & head_s.pol;
      REG_CTRL: begin
        rdata_s[CTRL_EN]     = enable_r;
        rdata_s[CTRL_IRQ_EN] = irq_en_r;
      end
      REG_THRESH:   rdata_s[THRESH_W-1:0] = thresh_r;
      REG_DROPS:    rdata_s[DROPS_W-1:0]  = drops_r;
      default:      rdata_s = 32'd0;
    endcase
  end

  // Registered read data, zero when the page is not addressed so buses can OR.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do_r <= 32'd0;
    end else if (sel_s) begin
      csr_do_r <= rdata_s;
    end else begin
      csr_do_r <= 32'd0;
    end
  end

endmodule
